// File: rtl/ixc_assign_pipe_if.sv
// Valid/ready bus for the ixc_assign_pipe retiming pipe: R side in, L side out, plus occupancy.
// slave is the pipe's view; master is the source/sink view.
interface ixc_assign_pipe_if #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] R;
  logic             r_vld;
  logic             r_rdy;
  logic [WIDTH-1:0] L;
  logic             l_vld;
  logic             l_rdy;
  logic [OCC_W-1:0] occ;

  modport slave (
    input  R, r_vld, l_rdy,
    output r_rdy, L, l_vld, occ
  );

  modport master (
    output R, r_vld, l_rdy,
    input  r_rdy, L, l_vld, occ
  );
endinterface

// File: rtl/ixc_assign_pipe.sv
// DEPTH-stage valid/ready retiming pipe for a WIDTH-bit assign, full throughput, bubbles collapse.
// Optional macro IXC_ASSIGN_PIPE_CNT_EN adds a saturating 32-bit output-transfer counter port `beats`.
module ixc_assign_pipe #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  ixc_assign_pipe_if.slave   bus
`ifdef IXC_ASSIGN_PIPE_CNT_EN
  ,
  output logic [31:0]        beats
`endif
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_in_v;
  logic [WIDTH-1:0] w_in_d [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Stage i may advance when it or any stage after it is empty, or the sink is taking a beat.
  always_comb begin : adv_chain
    logic acc;
    acc   = bus.l_rdy;
    w_adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc      = acc | ~r_v[i];
      w_adv[i] = acc;
    end
  end

  // Incoming valid/data per stage: the R port for stage 0, the previous stage otherwise.
  always_comb begin
    w_in_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_in_d[i] = '0;
    end
    w_in_v[0] = bus.r_vld;
    w_in_d[0] = bus.R;
    for (int i = 1; i < DEPTH; i++) begin
      w_in_v[i] = r_v[i-1];
      w_in_d[i] = r_d[i-1];
    end
  end

  // Transfer strobes at both ends of the pipe.
  always_comb begin
    w_in_xfer  = bus.r_vld & w_adv[0];
    w_out_xfer = r_v[DEPTH-1] & bus.l_rdy;
  end

  // Stage registers; data only loads under a valid beat so a bubble never clobbers it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_in_v[i];
          if (w_in_v[i]) begin
            r_d[i] <= w_in_d[i];
          end else begin
            r_d[i] <= r_d[i];
          end
        end else begin
          r_v[i] <= r_v[i];
          r_d[i] <= r_d[i];
        end
      end
    end
  end

  // Occupancy tracks the popcount of r_v without an adder tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef IXC_ASSIGN_PIPE_CNT_EN
  logic [31:0] r_beats;

  // Saturating count of beats delivered to the sink.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats <= 32'd0;
    end else if (w_out_xfer && (r_beats != 32'hFFFF_FFFF)) begin
      r_beats <= r_beats + 32'd1;
    end else begin
      r_beats <= r_beats;
    end
  end

  assign beats = r_beats;
`endif

  assign bus.r_rdy = w_adv[0];
  assign bus.L     = r_d[DEPTH-1];
  assign bus.l_vld = r_v[DEPTH-1];
  assign bus.occ   = r_occ;

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed bench for ixc_assign_pipe: reset, latency, streaming, backpressure, mid-flight reset, stalls.
// A scoreboard queue holds accepted beats; every delivered beat must match the queue head.
module tb_ixc_assign_pipe;
  parameter int WIDTH = 83;
  parameter int DEPTH = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] sb [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_l;
  logic [WIDTH-1:0] bp [DEPTH+1];
  logic [WIDTH-1:0] beat_a;

`ifdef IXC_ASSIGN_PIPE_CNT_EN
  logic [31:0] beats;
`endif

  ixc_assign_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ixc_assign_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef IXC_ASSIGN_PIPE_CNT_EN
    ,
    .beats (beats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.r_vld = 1'b0;
    bus.l_rdy = 1'b1;
    for (int n = 0; n < 4 * DEPTH + 10; n++) begin
      if (bus.occ == 0 && bus.l_vld == 1'b0) break;
      tick();
    end
    chk("drain_occ", bus.occ, 0);
    chk("drain_lvld", bus.l_vld, 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  // Scoreboard: record accepted beats, match delivered beats, and watch stalled outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_lvld", bus.l_vld, 1);
        chk("hold_L", bus.L, prev_l);
      end
      if (bus.r_vld === 1'b1 && bus.r_rdy === 1'b1) sb.push_back(bus.R);
      if (bus.l_vld === 1'b1 && bus.l_rdy === 1'b1) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL spurious_out observed=%0h expected=no_beat", bus.L);
        end
        if (sb.size() > 0) chk("order_L", bus.L, sb.pop_front());
      end
      prev_stall = (bus.l_vld === 1'b1 && bus.l_rdy === 1'b0);
      prev_l     = bus.L;
    end
  end

  initial begin
    int idx;
    int nfill;
    rst       = 1'b1;
    bus.r_vld = 1'b1;
    bus.R     = WIDTH'(32'h5A5A_5A5A);
    bus.l_rdy = 1'b0;

    // reset held two cycles while the source offers a beat
    tick();
    tick();
    chk("rst_L", bus.L, 0);
    chk("rst_lvld", bus.l_vld, 0);
    chk("rst_occ", bus.occ, 0);
`ifdef IXC_ASSIGN_PIPE_CNT_EN
    chk("rst_beats", beats, 0);
`endif
    rst       = 1'b0;
    bus.r_vld = 1'b0;
    #1;
    chk("rst_rrdy", bus.r_rdy, 1);

    // single beat latency
    beat_a    = 83'h7_DEAD_BEEF_0123_4567_89AB;
    bus.l_rdy = 1'b1;
    bus.R     = beat_a;
    bus.r_vld = 1'b1;
    tick();
    bus.r_vld = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k < DEPTH) begin
        chk("lat_early", bus.l_vld, 0);
      end else begin
        chk("lat_lvld", bus.l_vld, 1);
        chk("lat_L", bus.L, beat_a);
      end
      tick();
    end
    chk("lat_after", bus.l_vld, 0);

    // streaming 0..15 at full rate
    for (int c = 0; c < 16 + DEPTH; c++) begin
      if (c >= DEPTH) begin
        chk("stream_lvld", bus.l_vld, 1);
        chk("stream_L", bus.L, c - DEPTH);
      end
      bus.r_vld = (c < 16);
      bus.R     = WIDTH'(c);
      #1;
      if (c < 16) chk("stream_rrdy", bus.r_rdy, 1);
      tick();
    end
    drain();

    // backpressure: fill to DEPTH, hold, then release
    for (int k = 0; k <= DEPTH; k++) begin
      bp[k] = WIDTH'({$urandom(), $urandom(), $urandom()});
    end
    bus.l_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.R     = bp[k];
      bus.r_vld = 1'b1;
      #1;
      chk("bp_rrdy", bus.r_rdy, 1);
      tick();
      chk("bp_occ", bus.occ, k + 1);
    end
    bus.R = bp[DEPTH];
    #1;
    chk("bp_full_rrdy", bus.r_rdy, 0);
    chk("bp_full_occ", bus.occ, DEPTH);
    chk("bp_full_lvld", bus.l_vld, 1);
    chk("bp_full_L", bus.L, bp[0]);
    for (int k = 0; k < 3; k++) begin
      bus.R = WIDTH'({$urandom(), $urandom(), $urandom()});
      tick();
      chk("bp_hold_L", bus.L, bp[0]);
      chk("bp_hold_occ", bus.occ, DEPTH);
      chk("bp_hold_rrdy", bus.r_rdy, 0);
    end
    bus.R     = bp[DEPTH];
    bus.l_rdy = 1'b1;
    #1;
    chk("bp_full_accept", bus.r_rdy, 1);
    tick();
    chk("bp_swap_occ", bus.occ, DEPTH);
    drain();

    // reset with beats in flight
    nfill     = (DEPTH < 2) ? DEPTH : 2;
    bus.l_rdy = 1'b0;
    for (int k = 0; k < nfill; k++) begin
      bus.R     = WIDTH'(32'hC0DE_0000 + k);
      bus.r_vld = 1'b1;
      tick();
    end
    bus.r_vld = 1'b0;
    chk("mf_occ", bus.occ, nfill);
    rst = 1'b1;
    tick();
    sb.delete();
    chk("mf_rst_occ", bus.occ, 0);
    chk("mf_rst_lvld", bus.l_vld, 0);
    chk("mf_rst_L", bus.L, 0);
    rst       = 1'b0;
    bus.l_rdy = 1'b1;
    #1;
    chk("mf_rrdy", bus.r_rdy, 1);
    for (int k = 0; k < 2 * DEPTH + 2; k++) begin
      tick();
      chk("mf_no_out", bus.l_vld, 0);
    end

    // five beats under random sink stalls
    idx = 0;
    for (int c = 0; c < 200 && idx < 5; c++) begin
      bus.R     = WIDTH'({$urandom(), $urandom(), $urandom()});
      bus.r_vld = 1'b1;
      bus.l_rdy = 1'($urandom_range(0, 1));
      #1;
      if (bus.r_rdy) idx++;
      tick();
    end
    chk("stall_accepted", idx, 5);
    drain();
`ifdef IXC_ASSIGN_PIPE_CNT_EN
    chk("cnt_beats", beats, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
